par_chk_seq: RTL and testbench

Serial, parametrised parity checker for the UART receive path. It accumulates parity on the fly as data bits are sampled, supports 5..DATA_WIDTH-bit frames and four parity modes (even, odd, mark, space), and checks the received parity bit. Results are registered and held until the next frame. A saturating error counter can be compiled in. It sits between the RX bit sampler and the RX FSM, which supplies the frame/bit strobes.

---
 rtl/par_chk_seq.sv | 117 +++++++++++
 tb/tb_par_chk_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/par_chk_seq.sv
// rtl/par_chk_seq.sv - serial UART RX parity checker; PAR_ERR_CNT_EN builds the saturating error counter
module par_chk_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              frame_start,
    input  logic [$clog2(DATA_WIDTH+1)-1:0]   data_len,
    input  logic [1:0]                        PAR_TYP,
    input  logic                              bit_valid,
    input  logic                              sampled_bit,
    input  logic                              par_chk_en,
    input  logic                              cnt_clr,
    output logic                              par_err,
    output logic                              par_done,
    output logic                              calc_par,
    output logic [CNT_WIDTH-1:0]              err_cnt
);

    localparam int LW = $clog2(DATA_WIDTH + 1);
    localparam logic [LW-1:0] DW_L = LW'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

    state_t          state, state_nxt;
    logic            acc;
    logic [LW-1:0]   bit_cnt;
    logic [LW-1:0]   len_q;
    logic [1:0]      mode_q;
    logic [LW-1:0]   cnt_inc;
    logic [LW-1:0]   len_sel;
    logic            acc_upd;
    logic            check;
    logic            exp_bit;
    logic            mism;

    assign cnt_inc = bit_cnt + 1'b1;
    // Out-of-range lengths fall back to the widest frame the block supports
    assign len_sel = ((data_len == '0) || (data_len > DW_L)) ? DW_L : data_len;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; frame_start restarts the frame from any state
    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = DATA;
        end else begin
            case (state)
                DATA:    if (bit_valid && (cnt_inc == len_q)) state_nxt = PAR;
                PAR:     if (par_chk_en) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // Per-state strobes and the expected parity bit for the latched mode
    always_comb begin
        acc_upd = (state == DATA) && bit_valid && !frame_start;
        check   = (state == PAR) && par_chk_en && !frame_start;
        case (mode_q)
            2'b00:   exp_bit = acc;
            2'b01:   exp_bit = ~acc;
            2'b10:   exp_bit = 1'b1;
            default: exp_bit = 1'b0;
        endcase
        mism = check && (sampled_bit != exp_bit);
    end

    // Accumulator, frame setup and registered check results
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc      <= 1'b0;
            bit_cnt  <= '0;
            len_q    <= DW_L;
            mode_q   <= 2'b00;
            par_err  <= 1'b0;
            par_done <= 1'b0;
            calc_par <= 1'b0;
        end else begin
            par_done <= check;
            calc_par <= exp_bit;
            if (frame_start) begin
                acc     <= 1'b0;
                bit_cnt <= '0;
                len_q   <= len_sel;
                mode_q  <= PAR_TYP;
                par_err <= 1'b0;
            end else begin
                if (acc_upd) begin
                    acc     <= acc ^ sampled_bit;
                    bit_cnt <= cnt_inc;
                end
                if (check) par_err <= mism;
            end
        end
    end

`ifdef PAR_ERR_CNT_EN
    // Saturating error counter; a clear in the same cycle as an error wins
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                      err_cnt <= '0;
        else if (cnt_clr)              err_cnt <= '0;
        else if (mism && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_par_chk_seq.sv
// tb/tb_par_chk_seq.sv - directed scoreboard bench for par_chk_seq
module tb_par_chk_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       frame_start;
    logic [3:0] data_len;
    logic [1:0] PAR_TYP;
    logic       bit_valid;
    logic       sampled_bit;
    logic       par_chk_en;
    logic       cnt_clr;
    logic       par_err;
    logic       par_done;
    logic       calc_par;
    logic [1:0] err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic       sb_q[$];
    logic       m_acc;
    logic [1:0] m_mode;
    logic [1:0] m_cnt;

    par_chk_seq #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .data_len(data_len),
        .PAR_TYP(PAR_TYP), .bit_valid(bit_valid), .sampled_bit(sampled_bit),
        .par_chk_en(par_chk_en), .cnt_clr(cnt_clr), .par_err(par_err),
        .par_done(par_done), .calc_par(calc_par), .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic exp_par(input logic [1:0] mode, input logic a);
        case (mode)
            2'b00:   return a;
            2'b01:   return ~a;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic start_frame(input logic [3:0] len, input logic [1:0] mode);
        frame_start = 1'b1;
        data_len    = len;
        PAR_TYP     = mode;
        m_mode      = mode;
        m_acc       = 1'b0;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid   = 1'b1;
            sampled_bit = data[i];
            m_acc       = m_acc ^ data[i];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_par(input string tag, input logic pbit, input logic clr);
        logic e;
        logic err;
        logic got;
        e   = exp_par(m_mode, m_acc);
        err = (pbit != e);
        sb_q.push_back(err);
`ifdef PAR_ERR_CNT_EN
        if (clr) m_cnt = 2'd0;
        else if (err && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
`endif
        par_chk_en  = 1'b1;
        sampled_bit = pbit;
        cnt_clr     = clr;
        tick();
        par_chk_en = 1'b0;
        cnt_clr    = 1'b0;
        check({tag, "_done"}, {7'd0, par_done}, 8'd1);
        got = sb_q.pop_front();
        check({tag, "_err"}, {7'd0, par_err}, {7'd0, got});
        check({tag, "_calc"}, {7'd0, calc_par}, {7'd0, e});
        check({tag, "_cnt"}, {6'd0, err_cnt}, {6'd0, m_cnt});
        tick();
        check({tag, "_pulse"}, {7'd0, par_done}, 8'd0);
        check({tag, "_hold"}, {7'd0, par_err}, {7'd0, got});
    endtask

    initial begin
        RST = 1'b0; frame_start = 1'b0; data_len = 4'd8; PAR_TYP = 2'b00;
        bit_valid = 1'b0; sampled_bit = 1'b0; par_chk_en = 1'b0; cnt_clr = 1'b0;
        m_acc = 1'b0; m_mode = 2'b00; m_cnt = 2'd0;
        tick(); tick();
        check("rst_err",  {7'd0, par_err},  8'd0);
        check("rst_done", {7'd0, par_done}, 8'd0);
        check("rst_calc", {7'd0, calc_par}, 8'd0);
        check("rst_cnt",  {6'd0, err_cnt},  8'd0);
        RST = 1'b1;
        tick();

        // Even, 8 bits, 0xA5, parity 0 -> no error
        start_frame(4'd8, 2'b00); send_bits(8'hA5, 8); send_par("even_a5", 1'b0, 1'b0);
        // Odd, 7 bits, 0x13, parity 1 -> error; parity 0 -> ok
        start_frame(4'd7, 2'b01); send_bits(8'h13, 7); send_par("odd_13_p1", 1'b1, 1'b0);
        start_frame(4'd7, 2'b01); send_bits(8'h13, 7); send_par("odd_13_p0", 1'b0, 1'b0);
        // Mark with parity 0 -> error; space with parity 0 -> ok
        start_frame(4'd8, 2'b10); send_bits(8'h00, 8); send_par("mark_p0", 1'b0, 1'b0);
        start_frame(4'd5, 2'b11); send_bits(8'h1F, 5); send_par("space_p0", 1'b0, 1'b0);

        // par_chk_en in IDLE is ignored
        par_chk_en = 1'b1; sampled_bit = 1'b1;
        tick();
        par_chk_en = 1'b0;
        check("idle_chk_done", {7'd0, par_done}, 8'd0);

        // Abort after 3 bits following an error frame, then a full frame
        start_frame(4'd8, 2'b10); send_bits(8'h00, 8); send_par("mark_p0b", 1'b0, 1'b0);
        start_frame(4'd8, 2'b00);
        check("abort_clr_err", {7'd0, par_err}, 8'd0);
        send_bits(8'h07, 3);
        check("abort_no_done", {7'd0, par_done}, 8'd0);
        start_frame(4'd8, 2'b00);
        check("abort2_no_done", {7'd0, par_done}, 8'd0);
        send_bits(8'h3C, 8); send_par("after_abort", 1'b1, 1'b0);

        // frame_start with par_chk_en in PAR: frame_start wins
        start_frame(4'd5, 2'b00); send_bits(8'h01, 5);
        frame_start = 1'b1; par_chk_en = 1'b1; sampled_bit = 1'b0;
        data_len = 4'd0; PAR_TYP = 2'b00; m_mode = 2'b00; m_acc = 1'b0;
        tick();
        frame_start = 1'b0; par_chk_en = 1'b0;
        check("fs_chk_done", {7'd0, par_done}, 8'd0);
        check("fs_chk_cnt",  {6'd0, err_cnt},  {6'd0, m_cnt});
        // data_len 0 is taken as 8 bits
        send_bits(8'hF1, 8); send_par("len0_as8", 1'b0, 1'b0);

        // Saturation of the 2-bit counter
        start_frame(4'd8, 2'b10); send_bits(8'h55, 8); send_par("sat_a", 1'b0, 1'b0);
        start_frame(4'd8, 2'b10); send_bits(8'h55, 8); send_par("sat_b", 1'b0, 1'b0);
        // Clear in the same cycle as an error
        start_frame(4'd6, 2'b11); send_bits(8'h2A, 6); send_par("clr_vs_err", 1'b1, 1'b1);

        // Asynchronous reset in DATA
        start_frame(4'd8, 2'b10); send_bits(8'h03, 2);
        tick();
        check("pre_rst_calc", {7'd0, calc_par}, 8'd1);
        #2;
        RST = 1'b0;
        #1;
        check("arst_err",  {7'd0, par_err},  8'd0);
        check("arst_done", {7'd0, par_done}, 8'd0);
        check("arst_calc", {7'd0, calc_par}, 8'd0);
        check("arst_cnt",  {6'd0, err_cnt},  8'd0);
        m_cnt = 2'd0;
        tick();
        RST = 1'b1;
        tick();
        start_frame(4'd8, 2'b01); send_bits(8'hFF, 8); send_par("post_rst", 1'b0, 1'b0);

        check("sb_empty", 8'(sb_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
